// File: rtl/hs_stream_checker.sv
// Sink endpoint for valid/ready byte streams: applies back-pressure, checks beats
// against an incrementing reference and flags sender handshake violations.
module hs_stream_checker #(
    parameter int              DW         = 8,
    parameter logic [DW-1:0]   START_VAL  = DW'(1),
    parameter int              TARGET     = 200,
    parameter logic [15:0]     LFSR_SEED  = 16'hACE1,
    parameter logic [1:0]      STALL_MASK = 2'b01
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_en,
    input  logic          random_stall,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic [15:0]   xfer_cnt,
    output logic [15:0]   err_cnt,
    output logic          proto_err,
    output logic [DW-1:0] first_err_data,
    output logic [DW-1:0] first_err_exp,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic          ready_q, ready_d;
    logic [15:0]   xfer_cnt_q, xfer_cnt_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic          proto_err_q, proto_err_d;
    logic [DW-1:0] first_err_data_q, first_err_data_d;
    logic [DW-1:0] first_err_exp_q, first_err_exp_d;
    logic          done_q, done_d;
    logic [DW-1:0] exp_q, exp_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          pend_q, pend_d;
    logic [DW-1:0] hold_q, hold_d;

    logic xfer;
    logic lfsr_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d          = state_q;
        xfer_cnt_d       = xfer_cnt_q;
        err_cnt_d        = err_cnt_q;
        proto_err_d      = proto_err_q;
        first_err_data_d = first_err_data_q;
        first_err_exp_d  = first_err_exp_q;
        exp_d            = exp_q;
        lfsr_d           = lfsr_q;

        xfer = valid_i & ready_q;
        // A zero mask disables LFSR stalls instead of matching every cycle.
        lfsr_hit = (STALL_MASK != 2'b00) && ((lfsr_q[1:0] & STALL_MASK) == STALL_MASK);

        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (xfer && xfer_cnt_q == 16'(TARGET - 1)) state_d = DONE;
            default: state_d = DONE;
        endcase

        if (state_q == RUN)
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        if (xfer) begin
            xfer_cnt_d = sat_inc(xfer_cnt_q);
            exp_d      = exp_q + 1'b1;
            if (data_i != exp_q) begin
                err_cnt_d = sat_inc(err_cnt_q);
                if (err_cnt_q == 16'd0) begin
                    first_err_data_d = data_i;
                    first_err_exp_d  = exp_q;
                end
            end
        end

        // A beat refused at one edge must be re-presented unchanged at the next.
        pend_d = valid_i & ~ready_q;
        hold_d = data_i;
        if (pend_q && (!valid_i || data_i != hold_q))
            proto_err_d = 1'b1;

        ready_d = (state_d == RUN) & ~random_stall & ~(stall_en & lfsr_hit);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            ready_q          <= 1'b0;
            xfer_cnt_q       <= '0;
            err_cnt_q        <= '0;
            proto_err_q      <= 1'b0;
            first_err_data_q <= '0;
            first_err_exp_q  <= '0;
            done_q           <= 1'b0;
            exp_q            <= START_VAL;
            lfsr_q           <= LFSR_SEED;
            pend_q           <= 1'b0;
            hold_q           <= '0;
        end else begin
            state_q          <= state_d;
            ready_q          <= ready_d;
            xfer_cnt_q       <= xfer_cnt_d;
            err_cnt_q        <= err_cnt_d;
            proto_err_q      <= proto_err_d;
            first_err_data_q <= first_err_data_d;
            first_err_exp_q  <= first_err_exp_d;
            done_q           <= done_d;
            exp_q            <= exp_d;
            lfsr_q           <= lfsr_d;
            pend_q           <= pend_d;
            hold_q           <= hold_d;
        end
    end

    assign ready_o        = ready_q;
    assign xfer_cnt       = xfer_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign proto_err      = proto_err_q;
    assign first_err_data = first_err_data_q;
    assign first_err_exp  = first_err_exp_q;
    assign done           = done_q;

endmodule

// File: doc/hs_stream_checker.md
# hs_stream_checker

Sink-side endpoint for the valid/ready byte-stream bridges. It sits at the post-stage output of a handshake bridge under test and applies pseudo-random or externally forced back-pressure. It checks every accepted beat against an incrementing reference sequence, and detects sender-side protocol violations. It reports error and transfer counts plus a done flag, so benches reduce to a pass/fail on `err_cnt == 0`.

## Interface
- `DW`, 8, data width.
- `START_VAL`, 1, expected value of the first accepted beat.
- `TARGET`, 200, number of accepted beats after which the checker stops (1..65535).
- `LFSR_SEED`, 16'hACE1, non-zero reset value of the internal 16-bit stall LFSR.
- `STALL_MASK`, 2'b01: when `stall_en` is high, a stall fires when `(lfsr[1:0] & STALL_MASK) == STALL_MASK`. 2'b00 never stalls via LFSR.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `stall_en`  in  1  enables LFSR-driven stalls.
- `random_stall`  in  1  external stall request; forces `ready_o` low on the next cycle.
- `valid_i`  in  1  beat valid from the upstream bridge.
- `data_i`  in  DW  beat data.
- `ready_o`  out  1  registered ready to the upstream bridge.
- `xfer_cnt`  out  16  accepted beats, saturating.
- `err_cnt`  out  16  data mismatches, saturating.
- `proto_err`  out  1  sticky; set on any handshake-rule violation by the sender.
- `first_err_data`  out  DW  `data_i` of the first mismatching beat.
- `first_err_exp`  out  DW  expected value at the first mismatch.
- `done`  out  1  high once `xfer_cnt == TARGET`.

## Operation
- Reset (`rst_n == 0` at a rising edge): `ready_o = 0`, `xfer_cnt = 0`, `err_cnt = 0`, `proto_err = 0`, `first_err_* = 0`, `done = 0`, expected = `START_VAL`, LFSR = `LFSR_SEED`, state = IDLE.
- Reset asserted mid-stream discards all history. Any beat presented during the reset cycle is not counted.
- FSM:
  - IDLE: exactly one cycle with `ready_o = 0`, then go to RUN.
  - RUN: accept and check beats. Go to DONE on the edge where the accepted beat makes `xfer_cnt == TARGET`.
  - DONE: `ready_o = 0` permanently and `done = 1` until reset.
- LFSR: Fibonacci, taps 16,14,13,11. Advances every cycle in RUN, regardless of handshake.
- Next ready: `ready_o` next = `(state_next == RUN) & ~random_stall & ~(stall_en & lfsr_hit)`.
- Transfer: a beat transfers on any rising edge with `valid_i & ready_o`.
  - `xfer_cnt` increments (saturates at 16'hFFFF).
  - Expected advances by 1, modulo 2^DW: after 8'hFF comes 8'h00.
- Mismatch (`data_i != expected` on a transfer):
  - `err_cnt` increments (saturates).
  - On the first mismatch only, capture `first_err_data` and `first_err_exp`.
  - Expected still advances from its own value, not resynchronised to `data_i`.
- Protocol rule: if `valid_i & ~ready_o` at an edge, then at the next edge `valid_i` must be 1 and `data_i` must be unchanged. Otherwise set `proto_err`. The check also runs while in DONE.

## Timing
- `ready_o` is a pure register: no combinational path from `valid_i` or `data_i`.
- `random_stall` or an LFSR hit sampled at edge N takes effect as `ready_o = 0` during cycle N+1.
- Counter and flag updates are visible the cycle after the transfer edge.
- `done` rises in the cycle after the `TARGET`-th transfer. `ready_o` is already 0 in that same cycle.
- Back-to-back transfers sustain 1 beat/cycle with `stall_en = 0` and `random_stall = 0`.
- Simultaneous events:
  - A stall request on the edge of a transfer does not cancel that transfer.
  - A mismatch on the `TARGET`-th beat is counted before DONE.

## Test plan
- No stalls, sender streams 1,2,3…:
  - `ready_o` first high 2 cycles after reset release.
  - `TARGET = 200` beats complete in 200 consecutive cycles.
  - `done = 1`, `xfer_cnt = 200`, `err_cnt = 0`, `proto_err = 0`.
- `stall_en = 1` with `STALL_MASK = 2'b11`, plus random `random_stall` and random sender stalls:
  - All 200 beats accepted in order.
  - `err_cnt = 0`.
  - Total cycles greater than 200.
- Sender skips value 5 (sends 1,2,3,4,6,7…):
  - `err_cnt` ends at 196, i.e. every beat from the 5th onward mismatches.
  - `first_err_data = 6`, `first_err_exp = 5`.
- `DW = 8`, `START_VAL = 8'hFE`, `TARGET = 4`, sender sends FE,FF,00,01:
  - `err_cnt = 0`, `done = 1`.
- Sender drops `valid_i` while `ready_o = 0` (forced by `random_stall`):
  - `proto_err = 1` one cycle later.
  - A second stall where sender changes `data_i` also holds `proto_err = 1`.
- Reset pulsed after 50 beats, then 200 beats streamed from 1:
  - All outputs return to reset values the cycle after the reset edge.
  - Final `xfer_cnt = 200`, `err_cnt = 0`.
